// File: rtl/id_stage.sv
// Decode-stage front end: holds one fetched instruction, reads operands, resolves
// LoongArch32 branches and hands decoded instructions to execute.
module id_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         fs_to_ds_valid,
  input  logic [63:0]  fs_to_ds_bus,
  output logic         ds_allowin,
  output logic [33:0]  br_bus,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic         rf_hazard,
  input  logic         es_allowin,
  output logic         ds_to_es_valid,
  output logic [127:0] ds_to_es_bus
);

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic [31:0] ds_inst_q, ds_inst_d;

  logic [5:0]  op;
  logic        is_jirl, is_b_bl, is_br_reg, is_branch, uses_rj;
  logic [31:0] off16, off26;
  logic [31:0] rj_value, rkd_value;
  logic        rj_eq, rj_lt_s, rj_lt_u;
  logic        cond_true;
  logic [31:0] target;
  logic        ds_ready_go;
  logic        br_taken, br_stall;
  logic [31:0] br_target;

  assign op        = ds_inst_q[31:26];
  assign is_jirl   = (op == OP_JIRL);
  assign is_b_bl   = (op == OP_B) || (op == OP_BL);
  assign is_br_reg = (op >= OP_BEQ) && (op <= OP_BGEU);
  assign is_branch = is_jirl | is_b_bl | is_br_reg;
  assign uses_rj   = is_jirl | is_br_reg;

  // Conditional branches compare rj against rd, so port 2 reads rd for them.
  assign rf_raddr1 = ds_inst_q[9:5];
  assign rf_raddr2 = is_br_reg ? ds_inst_q[4:0] : ds_inst_q[14:10];
  assign rj_value  = rf_rdata1;
  assign rkd_value = rf_rdata2;

  assign off16 = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b00};
  assign off26 = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b00};

  assign rj_eq   = (rj_value == rkd_value);
  assign rj_lt_s = ($signed(rj_value) < $signed(rkd_value));
  assign rj_lt_u = (rj_value < rkd_value);

  always_comb begin
    cond_true = 1'b0;
    case (op)
      OP_JIRL, OP_B, OP_BL: cond_true = 1'b1;
      OP_BEQ:               cond_true = rj_eq;
      OP_BNE:               cond_true = ~rj_eq;
      OP_BLT:               cond_true = rj_lt_s;
      OP_BGE:               cond_true = ~rj_lt_s;
      OP_BLTU:              cond_true = rj_lt_u;
      OP_BGEU:              cond_true = ~rj_lt_u;
      default:              cond_true = 1'b0;
    endcase
  end

  always_comb begin
    target = ds_pc_q + off16;
    if (is_b_bl)
      target = ds_pc_q + off26;
    else if (is_jirl)
      target = rj_value + off16;
  end

  // b/bl read no registers, so only they may proceed under a pending hazard.
  assign ds_ready_go    = ~(rf_hazard & (uses_rj | ~is_b_bl));
  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go;

  assign br_taken  = ds_valid_q & is_branch & cond_true & ds_ready_go & es_allowin;
  assign br_stall  = ds_valid_q & is_branch & ~ds_ready_go;
  assign br_target = ds_valid_q ? target : 32'h0;
  assign br_bus    = {br_stall, br_taken, br_target};

  assign ds_to_es_bus = {ds_pc_q, ds_inst_q, rj_value, rkd_value};

  // A taken branch leaving this edge squashes the fall-through crossing with it.
  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_pc_d    = ds_pc_q;
    ds_inst_d  = ds_inst_q;
    if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid & ~br_taken;
      if (fs_to_ds_valid) begin
        ds_pc_d   = fs_to_ds_bus[63:32];
        ds_inst_d = fs_to_ds_bus[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      ds_pc_q    <= 32'h0;
      ds_inst_q  <= 32'h0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_pc_q    <= ds_pc_d;
      ds_inst_q  <= ds_inst_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: table of single-instruction decode vectors
// plus hand-written multi-cycle sequences (reset, kill, hazard, backpressure).
module tb_id_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_allowin;
  logic [33:0]  br_bus;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic         rf_hazard;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [127:0] ds_to_es_bus;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .resetn(resetn),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .br_bus(br_bus),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_hazard(rf_hazard), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] pc, inst, r1, r2;
    logic        haz, esa;
    logic        taken, stall;
    logic [31:0] target;
    logic        chk_tgt;
    logic        dsv, alw;
    logic [4:0]  ra1, ra2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [31:0] pc, inst, r1, r2,
                              input logic haz, esa, taken, stall,
                              input logic [31:0] target, input logic chk_tgt,
                              input logic dsv, alw, input logic [4:0] ra1, ra2);
    vec_t v;
    v.name = name; v.pc = pc; v.inst = inst; v.r1 = r1; v.r2 = r2;
    v.haz = haz; v.esa = esa; v.taken = taken; v.stall = stall;
    v.target = target; v.chk_tgt = chk_tgt; v.dsv = dsv; v.alw = alw;
    v.ra1 = ra1; v.ra2 = ra2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Flush decode, then accept one instruction; returns at the negedge after it is held.
  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    fs_to_ds_valid = 1'b0; rf_hazard = 1'b0; es_allowin = 1'b1;
    cyc();
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {pc, inst};
    cyc();
    fs_to_ds_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; fs_to_ds_valid = 1'b0; fs_to_ds_bus = 64'h0;
    rf_rdata1 = 32'h0; rf_rdata2 = 32'h0; rf_hazard = 1'b0; es_allowin = 1'b1;

    //          name       pc            inst          r1            r2            haz esa tk st target        ct dsv alw ra1 ra2
    vecs.push_back(mk("beq_t",   32'h1c000010, 32'h58001085, 32'd5,        32'd5,        0, 1, 1, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("beq_nt",  32'h1c000010, 32'h58001085, 32'd5,        32'd6,        0, 1, 0, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("bne_nt",  32'h1c000010, 32'h5c001085, 32'd5,        32'd5,        0, 1, 0, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("bne_t",   32'h1c000010, 32'h5c001085, 32'd5,        32'd6,        0, 1, 1, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("blt_s",   32'h1c000010, 32'h60001085, 32'hffffffff, 32'd1,        0, 1, 1, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("bltu_nt", 32'h1c000010, 32'h68001085, 32'hffffffff, 32'd1,        0, 1, 0, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("bge_s",   32'h1c000010, 32'h64001085, 32'd1,        32'hffffffff, 0, 1, 1, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("bge_eq",  32'h1c000010, 32'h64001085, 32'd7,        32'd7,        0, 1, 1, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    vecs.push_back(mk("bgeu_nt", 32'h1c000010, 32'h6c001085, 32'd1,        32'hffffffff, 0, 1, 0, 0, 32'h1c000020, 1, 1, 1, 5'd4,  5'd5));
    // b -16 taken regardless of a pending hazard
    vecs.push_back(mk("b_back",  32'h1c000100, 32'h53fff3ff, 32'd0,        32'd0,        1, 1, 1, 0, 32'h1c0000f0, 1, 1, 1, 5'd31, 5'd28));
    vecs.push_back(mk("bl_fwd",  32'h1c000200, 32'h54000800, 32'd0,        32'd0,        0, 1, 1, 0, 32'h1c000208, 1, 1, 1, 5'd0,  5'd2));
    vecs.push_back(mk("jirl_o",  32'h1c000300, 32'h4c001081, 32'h1c000400, 32'd0,        0, 1, 1, 0, 32'h1c000410, 1, 1, 1, 5'd4,  5'd4));
    vecs.push_back(mk("addi",    32'h1c000000, 32'h0280040c, 32'd0,        32'd0,        0, 1, 0, 0, 32'h0,        0, 1, 1, 5'd0,  5'd1));
    vecs.push_back(mk("addi_hz", 32'h1c000000, 32'h0280040c, 32'd0,        32'd0,        1, 1, 0, 0, 32'h0,        0, 0, 0, 5'd0,  5'd1));
    vecs.push_back(mk("beq_hz",  32'h1c000010, 32'h58001085, 32'd5,        32'd5,        1, 1, 0, 1, 32'h1c000020, 1, 0, 0, 5'd4,  5'd5));
    vecs.push_back(mk("beq_bp",  32'h1c000010, 32'h58001085, 32'd5,        32'd5,        0, 0, 0, 0, 32'h1c000020, 1, 1, 0, 5'd4,  5'd5));
    vecs.push_back(mk("addi_bp", 32'h1c000000, 32'h0280040c, 32'd0,        32'd0,        0, 0, 0, 0, 32'h0,        0, 1, 0, 5'd0,  5'd1));

    // Reset values
    #1;
    chk("rst_allowin", ds_allowin, 1'b1);
    chk("rst_br_bus", br_bus, 34'h0);
    chk("rst_to_es_valid", ds_to_es_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      load(vecs[i].pc, vecs[i].inst);
      rf_rdata1 = vecs[i].r1; rf_rdata2 = vecs[i].r2;
      rf_hazard = vecs[i].haz; es_allowin = vecs[i].esa;
      #1;
      chk({vecs[i].name, ".taken"}, br_bus[32], vecs[i].taken);
      chk({vecs[i].name, ".stall"}, br_bus[33], vecs[i].stall);
      if (vecs[i].chk_tgt) chk({vecs[i].name, ".target"}, br_bus[31:0], vecs[i].target);
      chk({vecs[i].name, ".to_es_valid"}, ds_to_es_valid, vecs[i].dsv);
      chk({vecs[i].name, ".allowin"}, ds_allowin, vecs[i].alw);
      chk({vecs[i].name, ".raddr1"}, rf_raddr1, vecs[i].ra1);
      chk({vecs[i].name, ".raddr2"}, rf_raddr2, vecs[i].ra2);
      chk({vecs[i].name, ".bus"}, ds_to_es_bus, {vecs[i].pc, vecs[i].inst, vecs[i].r1, vecs[i].r2});
    end

    // Mid-run reset drops the held instruction, then the first fetch lands one cycle later
    load(32'h1c000010, 32'h58001085);
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd6;
    resetn = 1'b0;
    #1;
    chk("mrst_allowin", ds_allowin, 1'b1);
    chk("mrst_br_bus", br_bus, 34'h0);
    chk("mrst_to_es_valid", ds_to_es_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h1c000000, 32'h0280040c};
    cyc();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("mrst_first_valid", ds_to_es_valid, 1'b1);
    chk("mrst_first_bus", ds_to_es_bus[127:64], {32'h1c000000, 32'h0280040c});
    @(negedge clk);

    // beq taken kills the fall-through offered in the same cycle
    load(32'h1c000010, 32'h58001085);
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd5;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h1c000014, 32'h0280040c};
    #1;
    chk("kill_taken", br_bus[32], 1'b1);
    chk("kill_target", br_bus[31:0], 32'h1c000020);
    chk("kill_allowin", ds_allowin, 1'b1);
    cyc();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("kill_fallthrough", ds_to_es_valid, 1'b0);
    chk("kill_no_retake", br_bus[32], 1'b0);
    @(negedge clk);

    // bne not taken: the sequential instruction is accepted
    load(32'h1c000010, 32'h5c001085);
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd5;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h1c000014, 32'h0280040c};
    #1;
    chk("bne_seq_taken", br_bus[32], 1'b0);
    chk("bne_seq_stall", br_bus[33], 1'b0);
    cyc();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("bne_seq_valid", ds_to_es_valid, 1'b1);
    chk("bne_seq_pc", ds_to_es_bus[127:96], 32'h1c000014);
    @(negedge clk);

    // jirl stalled by a hazard for three cycles, then a single taken pulse
    load(32'h1c000300, 32'h4c000081);
    rf_rdata1 = 32'h1c000400; rf_hazard = 1'b1;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h1c000304, 32'h0280040c};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("jirl_hz_stall", br_bus[33], 1'b1);
      chk("jirl_hz_taken", br_bus[32], 1'b0);
      chk("jirl_hz_valid", ds_to_es_valid, 1'b0);
      chk("jirl_hz_allowin", ds_allowin, 1'b0);
      cyc();
    end
    rf_hazard = 1'b0;
    #1;
    chk("jirl_go_taken", br_bus[32], 1'b1);
    chk("jirl_go_stall", br_bus[33], 1'b0);
    chk("jirl_go_target", br_bus[31:0], 32'h1c000400);
    chk("jirl_go_valid", ds_to_es_valid, 1'b1);
    cyc();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("jirl_pulse_end", br_bus[32], 1'b0);
    chk("jirl_killed", ds_to_es_valid, 1'b0);
    @(negedge clk);

    // Backpressure holds a taken beq until execute accepts
    load(32'h1c000010, 32'h58001085);
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd5; es_allowin = 1'b0;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h1c000014, 32'h0280040c};
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_taken", br_bus[32], 1'b0);
      chk("bp_stall", br_bus[33], 1'b0);
      chk("bp_allowin", ds_allowin, 1'b0);
      chk("bp_pc_hold", ds_to_es_bus[127:96], 32'h1c000010);
      cyc();
    end
    es_allowin = 1'b1;
    #1;
    chk("bp_release_taken", br_bus[32], 1'b1);
    chk("bp_release_target", br_bus[31:0], 32'h1c000020);
    cyc();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("bp_release_kill", ds_to_es_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
